// File: rtl/state_dump_sequencer.sv
// Post-run state dump for the single-cycle machine: streams a PC trace while running,
// then freezes the machine and serialises the register file and a data-memory window.
module state_dump_sequencer #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter int          NUM_REGS       = 32,
    parameter logic [31:0] MEM_BASE       = 32'h0000_4000,
    parameter int          MEM_BYTES      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        freeze,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_kind,
    output logic [31:0] out_data,
    output logic [1:0]  halt_cause,
    output logic        overflow,
    output logic        done
);

    localparam int CW      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int IDX_MAX = (NUM_REGS > MEM_BYTES) ? NUM_REGS : MEM_BYTES;
    localparam int IW      = $clog2(IDX_MAX) + 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DUMP_REG = 2'd1,
        DUMP_MEM = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [CW-1:0]   cyc_r;
    logic [IW-1:0]   idx_r;
    logic [1:0]      halt_cause_r;
    logic            overflow_r;
    logic            done_r;

    logic            inst0_s;
    logic            timeout_s;
    logic            halt_s;
    logic            valid_s;
    logic            freeze_s;
    logic [1:0]      kind_s;
    logic [31:0]     data_s;
    logic            last_reg_s;
    logic            last_mem_s;

    assign inst0_s    = (inst == 32'h0000_0000);
    assign timeout_s  = (cyc_r == CW'(TIMEOUT_CYCLES - 1));
    assign last_reg_s = (idx_r == IW'(NUM_REGS - 1));
    assign last_mem_s = (idx_r == IW'(MEM_BYTES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and per-state record/address selection.
    always_comb begin
        next_state_s = state_r;
        halt_s       = 1'b0;
        valid_s      = 1'b0;
        freeze_s     = 1'b0;
        kind_s       = 2'd0;
        data_s       = 32'h0000_0000;
        rf_addr      = 5'd0;
        mem_addr     = MEM_BASE;
        case (state_r)
            RUN: begin
                valid_s = 1'b1;
                kind_s  = 2'd0;
                data_s  = pc;
                if (inst0_s || timeout_s) begin
                    halt_s       = 1'b1;
                    next_state_s = DUMP_REG;
                end else begin
                    next_state_s = RUN;
                end
            end
            DUMP_REG: begin
                freeze_s = 1'b1;
                valid_s  = 1'b1;
                kind_s   = 2'd1;
                rf_addr  = 5'(idx_r);
                data_s   = rf_data;
                if (out_ready && last_reg_s) begin
                    next_state_s = DUMP_MEM;
                end else begin
                    next_state_s = DUMP_REG;
                end
            end
            DUMP_MEM: begin
                freeze_s = 1'b1;
                valid_s  = 1'b1;
                kind_s   = 2'd2;
                mem_addr = MEM_BASE + 32'(idx_r);
                data_s   = {24'h00_0000, mem_data};
                if (out_ready && last_mem_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = DUMP_MEM;
                end
            end
            DONE: begin
                freeze_s     = 1'b1;
                next_state_s = DONE;
            end
            default: begin
                next_state_s = RUN;
            end
        endcase
    end

    // Counters and sticky status; the halting cycle still counts as a RUN edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_r        <= '0;
            idx_r        <= '0;
            halt_cause_r <= 2'b00;
            overflow_r   <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    cyc_r <= cyc_r + CW'(1);
                    if (!out_ready) begin
                        overflow_r <= 1'b1;
                    end
                    if (halt_s) begin
                        halt_cause_r <= {timeout_s, inst0_s};
                        idx_r        <= '0;
                    end
                end
                DUMP_REG: begin
                    if (out_ready) begin
                        idx_r <= last_reg_s ? '0 : idx_r + IW'(1);
                    end
                end
                DUMP_MEM: begin
                    if (out_ready) begin
                        if (last_mem_s) begin
                            done_r <= 1'b1;
                        end else begin
                            idx_r <= idx_r + IW'(1);
                        end
                    end
                end
                DONE: begin
                    done_r <= 1'b1;
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

    // Reset overrides the stream and the machine hold immediately, not a cycle later.
    assign out_valid  = valid_s & ~reset;
    assign freeze     = freeze_s & ~reset;
    assign out_kind   = out_valid ? kind_s : 2'd0;
    assign out_data   = out_valid ? data_s : 32'h0000_0000;
    assign halt_cause = halt_cause_r;
    assign overflow   = overflow_r;
    assign done       = done_r;

endmodule

// File: tb/tb_state_dump_sequencer.sv
// Directed bench for state_dump_sequencer: halt causes, backpressure, PC drop, reset mid-dump.
module tb_state_dump_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data;
    logic        freeze;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [31:0] out_data;
    logic [1:0]  halt_cause;
    logic        overflow;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]  rec_kind [$];
    logic [31:0] rec_data [$];
    logic [31:0] exp_pc   [$];
    logic [7:0]  mem_exp  [4] = '{8'h5A, 8'h5B, 8'h58, 8'h59};

    state_dump_sequencer dut (
        .clk(clk), .reset(reset), .pc(pc), .inst(inst),
        .rf_addr(rf_addr), .rf_data(rf_data), .mem_addr(mem_addr), .mem_data(mem_data),
        .freeze(freeze), .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_data(out_data), .halt_cause(halt_cause),
        .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    // Register file and data memory stand-ins.
    assign rf_data  = 32'hA500_0100 + {27'd0, rf_addr};
    assign mem_data = mem_addr[7:0] ^ 8'h5A;

    // Capture every record the consumer accepts at the coming edge.
    always @(negedge clk) begin
        if (out_valid && out_ready && !reset) begin
            rec_kind.push_back(out_kind);
            rec_data.push_back(out_data);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        out_ready = 1'b1;
        inst      = 32'h0000_0013;
        pc        = 32'h0040_0000;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_freeze", {31'd0, freeze}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        rec_kind.delete();
        rec_data.delete();
        exp_pc.delete();
    endtask

    // Drive n RUN cycles; inst is zero at halt_at, out_ready low at drop_at.
    task automatic drive_run(input int n, input int halt_at, input int drop_at, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            pc        = base + 32'(4 * k);
            inst      = (k == halt_at) ? 32'h0000_0000 : 32'h0000_0013;
            out_ready = (k != drop_at);
            if (out_ready) exp_pc.push_back(pc);
            @(negedge clk);
            if (k == 0 || k == n - 1 || k == drop_at) begin
                check_eq("run_freeze", {31'd0, freeze}, 32'd0);
                check_eq("run_kind", {30'd0, out_kind}, 32'd0);
                check_eq("run_pc", out_data, pc);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        inst      = 32'h0000_0013;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            @(posedge clk); #1;
        end
        check_eq("done", {31'd0, done}, 32'd1);
        @(negedge clk);
        check_eq("done_freeze", {31'd0, freeze}, 32'd1);
        check_eq("done_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic verify_stream();
        int np;
        np = exp_pc.size();
        check_eq("rec_count", 32'(rec_kind.size()), 32'(np + 32 + 4));
        for (int i = 0; i < np; i++) begin
            check_eq("pc_kind", {30'd0, rec_kind[i]}, 32'd0);
            check_eq("pc_data", rec_data[i], exp_pc[i]);
        end
        for (int i = 0; i < 32; i++) begin
            check_eq("reg_kind", {30'd0, rec_kind[np + i]}, 32'd1);
            check_eq("reg_data", rec_data[np + i], 32'hA500_0100 + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            check_eq("mem_kind", {30'd0, rec_kind[np + 32 + i]}, 32'd2);
            check_eq("mem_data", rec_data[np + 32 + i], {24'd0, mem_exp[i]});
        end
    endtask

    initial begin
        // Inst halt at cycle 10.
        do_reset();
        check_eq("rst_cause", {30'd0, halt_cause}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        drive_run(11, 10, -1, 32'h0040_0000);
        @(negedge clk);
        check_eq("ih_freeze", {31'd0, freeze}, 32'd1);
        check_eq("ih_cause", {30'd0, halt_cause}, 32'd1);
        check_eq("ih_last_pc", exp_pc[10], 32'h0040_0028);
        @(posedge clk); #1;
        wait_done(100);
        verify_stream();
        check_eq("ih_overflow", {31'd0, overflow}, 32'd0);

        // Timeout after 64 RUN cycles.
        do_reset();
        drive_run(64, -1, -1, 32'h0000_1000);
        @(negedge clk);
        check_eq("to_freeze", {31'd0, freeze}, 32'd1);
        check_eq("to_kind", {30'd0, out_kind}, 32'd1);
        check_eq("to_cause", {30'd0, halt_cause}, 32'd2);
        @(posedge clk); #1;
        wait_done(100);
        verify_stream();

        // Inst zero on the timeout cycle.
        do_reset();
        drive_run(64, 63, -1, 32'h0000_2000);
        wait_done(100);
        check_eq("sim_cause", {30'd0, halt_cause}, 32'd3);
        verify_stream();

        // Backpressure at register 5.
        do_reset();
        drive_run(3, 2, -1, 32'h0000_3000);
        for (int i = 0; i < 50; i++) begin
            if (rf_addr == 5'd5) break;
            @(posedge clk); #1;
        end
        check_eq("bp_reach", {27'd0, rf_addr}, 32'd5);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_kind", {30'd0, out_kind}, 32'd1);
            check_eq("bp_data", out_data, 32'hA500_0105);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done(100);
        verify_stream();

        // Dropped PC record.
        do_reset();
        drive_run(6, 5, 2, 32'h0000_5000);
        check_eq("drop_ovf", {31'd0, overflow}, 32'd1);
        wait_done(100);
        check_eq("drop_ovf_done", {31'd0, overflow}, 32'd1);
        verify_stream();

        // Reset in the middle of the memory dump.
        do_reset();
        drive_run(2, 1, 0, 32'h0000_6000);
        for (int i = 0; i < 80; i++) begin
            if (mem_addr == 32'h0000_4002) break;
            @(posedge clk); #1;
        end
        check_eq("mr_reach", mem_addr, 32'h0000_4002);
        check_eq("mr_ovf_pre", {31'd0, overflow}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mr_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mr_rst_freeze", {31'd0, freeze}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        rec_kind.delete();
        rec_data.delete();
        exp_pc.delete();
        @(negedge clk);
        check_eq("mr_kind", {30'd0, out_kind}, 32'd0);
        check_eq("mr_valid", {31'd0, out_valid}, 32'd1);
        check_eq("mr_freeze", {31'd0, freeze}, 32'd0);
        check_eq("mr_done", {31'd0, done}, 32'd0);
        check_eq("mr_cause", {30'd0, halt_cause}, 32'd0);
        check_eq("mr_ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;
        rec_kind.delete();
        rec_data.delete();
        drive_run(4, 3, -1, 32'h0000_7000);
        wait_done(100);
        check_eq("mr2_cause", {30'd0, halt_cause}, 32'd1);
        verify_stream();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/state_dump_sequencer.md
Name: state_dump_sequencer

Overview:
- Sits directly downstream of the single-cycle `machine`. It consumes the machine's PC, current instruction, register-file read port and data-memory byte port.
- Streams a per-cycle PC trace while the machine runs. On halt (instruction word 0) or timeout, it freezes the machine.
- After freezing, it serialises all 32 registers, then a window of data-memory bytes, over one valid/ready record stream that feeds the autograder capture logic.

Parameters:
- TIMEOUT_CYCLES, 64, RUN cycles allowed before a forced halt (≥1).
- NUM_REGS, 32, registers dumped, indices 0..NUM_REGS-1.
- MEM_BASE, 32'h4000, first data-memory byte address dumped.
- MEM_BYTES, 4, number of bytes dumped (≥1).

Ports:
- clk, in, 1, system clock, rising-edge.
- reset, in, 1, synchronous, active-high.
- pc, in, 32, machine PC (byte address).
- inst, in, 32, instruction currently being executed.
- rf_addr, out, 5, register-file read index.
- rf_data, in, 32, combinational read data for rf_addr.
- mem_addr, out, 32, data-memory byte address.
- mem_data, in, 8, combinational read data for mem_addr.
- freeze, out, 1, clock-enable kill to the machine; high means hold.
- out_valid, out, 1, record valid.
- out_ready, in, 1, consumer accepts record.
- out_kind, out, 2, record kind: 0 = PC, 1 = REG, 2 = MEM.
- out_data, out, 32, record payload.
- halt_cause, out, 2, bit0 = inst==0, bit1 = timeout; sticky.
- overflow, out, 1, sticky: a PC record was dropped.
- done, out, 1, dump complete; held until reset.

Behaviour:
- Clock and reset:
  - One clock domain, `clk`. Reset is synchronous, active-high, named `reset`.
  - In any cycle with reset=1, at the edge: state←RUN, cyc←0, idx←0, halt_cause←0, overflow←0, done←0.
  - While reset=1, out_valid=0 and freeze=0 regardless of state.
- States: RUN, DUMP_REG, DUMP_MEM, DONE. Outputs are combinational from registered state, counters and inputs.
- RUN:
  - out_valid=1, out_kind=0, out_data=pc, freeze=0. One PC record per cycle; no backpressure.
  - If out_ready=0 in a RUN cycle, that record is dropped and overflow←1 (sticky).
  - cyc increments each RUN edge.
  - Halt condition: inst==32'h0 OR cyc==TIMEOUT_CYCLES-1. The halting cycle's PC record is still emitted.
  - On the halt edge: halt_cause←{timeout, inst0}, both bits set if both are true; idx←0; state←DUMP_REG.
  - The machine takes that edge; freeze asserts from the next cycle.
- DUMP_REG:
  - freeze=1, rf_addr=idx, out_valid=1, out_kind=1, out_data=rf_data.
  - Advance only on out_valid&&out_ready. The record holds stable while stalled.
  - When idx==NUM_REGS-1 is accepted: idx←0, state←DUMP_MEM. Otherwise idx←idx+1.
- DUMP_MEM:
  - freeze=1, mem_addr=MEM_BASE+idx, out_kind=2, out_data={24'b0, mem_data}.
  - Same handshake rule as DUMP_REG.
  - When idx==MEM_BYTES-1 is accepted: state←DONE.
- DONE:
  - freeze=1, out_valid=0, done=1. Stays in DONE until reset.
- Idle values:
  - rf_addr=0 and mem_addr=MEM_BASE whenever not in their dump state.
  - out_kind/out_data are 0 whenever out_valid=0.
- Reset mid-dump: abandons the dump immediately. The next cycle is RUN with cyc=0, and flags are cleared.
- Counter widths:
  - cyc is $clog2(TIMEOUT_CYCLES)+1 bits and never wraps, because halt occurs first.
  - idx is wide enough for max(NUM_REGS, MEM_BYTES).

Test Plan:
- Inst halt: hold out_ready=1; inst nonzero for 10 cycles, then 0 at cycle 10 with pc=0x00400028 → 11 PC records ending 0x00400028; halt_cause=01; then 32 REG records; freeze=1 from cycle 11.
- Timeout: inst never 0, TIMEOUT_CYCLES=64 → exactly 64 PC records; halt_cause=10; DUMP_REG begins at cycle 64.
- Simultaneous: inst==0 on cycle 63 with TIMEOUT_CYCLES=64 → halt_cause=11; single dump sequence.
- Backpressure:
  - During DUMP_REG, drop out_ready for 3 cycles at idx=5 → record (kind 1, rf_data of r5) holds stable; no skip or duplicate; 32+4 records total.
  - MEM records carry bytes at 0x4000..0x4003 zero-extended; then done=1.
- PC drop: out_ready=0 for one RUN cycle → overflow=1 and stays 1 through DONE; other PC records unaffected.
- Reset mid-dump: assert reset at MEM idx=2 → next cycle out_kind=0, freeze=0, done=0, halt_cause=0, overflow=0; a fresh run and dump complete normally.
